// File: rtl/cap_err_pkg.sv
// Shared types for the CHERI capability error-injection scheduler.
// Holds the mode/state encodings, the LFSR taps and the LFSR step function.
package cap_err_pkg;

    typedef enum logic [1:0] {
        MODE_OFF      = 2'd0,
        MODE_RANDOM   = 2'd1,
        MODE_PERIODIC = 2'd2,
        MODE_ONESHOT  = 2'd3
    } mode_e;

    // The INJECT cycle is an ARMED cycle that carries an eligible access,
    // so it needs no register encoding of its own.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ARMED = 2'd1,
        ST_CHECK = 2'd2
    } state_e;

    localparam logic [31:0] LFSR_TAPS = 32'h8020_0003;

    function automatic logic [31:0] lfsr_step(input logic [31:0] s);
        return {1'b0, s[31:1]} ^ (s[0] ? LFSR_TAPS : 32'h0);
    endfunction

endpackage

// File: rtl/cap_err_chan.sv
// One injection channel: arming policy, inject/check FSM and saturating stats.
// Ports: mode/rate/mask config, rnd (rotated LFSR), access + checker inputs; inj_* and cnt_* outputs.
module cap_err_chan
    import cap_err_pkg::*;
#(
    parameter int N_TYPES = 5,
    parameter int TYPE_W  = 3,
    parameter int CNT_W   = 16,
    parameter int TO_CYC  = 64
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [1:0]         mode,
    input  logic [2:0]         rate,
    input  logic [N_TYPES-1:0] mask,
    input  logic [31:0]        rnd,
    input  logic               req_valid,
    input  logic               req_excl,
    input  logic               req_done,
    input  logic               chk_valid,
    input  logic               chk_err,
    output logic               inj_active,
    output logic [TYPE_W-1:0]  inj_type,
    output logic [31:0]        inj_seed,
    output logic               inj_failed,
    output logic [CNT_W-1:0]   cnt_inj,
    output logic [CNT_W-1:0]   cnt_det,
    output logic [CNT_W-1:0]   cnt_miss
);

    localparam int TO_W = $clog2(TO_CYC + 1);

    mode_e            m;
    state_e           st;
    logic             os_used;
    logic [7:0]       pcnt;
    logic [TO_W-1:0]  to_cnt;

    logic             run;
    logic             idle_done;
    logic             rate_on;
    logic [7:0]       p_lim;
    logic             rnd_hit;
    logic             p_wrap;
    logic             to_hit;
    logic             det;
    logic             arm;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    // Start at seed mod N_TYPES and walk upward (wrapping) to the first
    // enabled type; callers guarantee the mask is non-zero.
    function automatic logic [TYPE_W-1:0] pick_type(
        input logic [15:0]        s,
        input logic [N_TYPES-1:0] msk
    );
        logic [2*N_TYPES-1:0] dm;
        logic [2*N_TYPES-1:0] sh;
        int unsigned          base;
        int unsigned          idx;
        logic                 found;
        dm    = {msk, msk};
        base  = {16'd0, s} % 32'(N_TYPES);
        idx   = base;
        found = 1'b0;
        for (int unsigned k = 0; k < N_TYPES; k++) begin
            sh = dm >> (base + k);
            if (!found && sh[0]) begin
                idx   = (base + k) % 32'(N_TYPES);
                found = 1'b1;
            end
        end
        return TYPE_W'(idx);
    endfunction

    assign m         = mode_e'(mode);
    assign run       = !rst && (m != MODE_OFF);
    assign idle_done = run && (st == ST_IDLE) && req_done;
    assign rate_on   = (rate != 3'd0);
    // 2^(8-rate)-1 doubles as the RANDOM bit mask and the PERIODIC limit.
    assign p_lim     = (8'd1 << (4'd8 - {1'b0, rate})) - 8'd1;
    assign rnd_hit   = ((rnd[7:0] & p_lim) == 8'd0);
    assign p_wrap    = (pcnt == p_lim);
    assign to_hit    = (to_cnt == TO_W'(TO_CYC - 1));

    assign inj_active = run && (st == ST_ARMED) && req_valid && !req_excl;
    assign det        = run && (st == ST_CHECK) && chk_valid && chk_err;
    assign inj_failed = run && (st == ST_CHECK) &&
                        (chk_valid ? !chk_err : to_hit);

    always_comb begin
        arm = 1'b0;
        if (idle_done && (|mask)) begin
            unique case (m)
                MODE_RANDOM:   arm = rate_on && rnd_hit;
                MODE_PERIODIC: arm = rate_on && p_wrap;
                MODE_ONESHOT:  arm = !os_used;
                default:       arm = 1'b0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            st       <= ST_IDLE;
            os_used  <= 1'b0;
            pcnt     <= 8'd0;
            to_cnt   <= '0;
            inj_seed <= 32'd0;
            inj_type <= '0;
            cnt_inj  <= '0;
            cnt_det  <= '0;
            cnt_miss <= '0;
        end else if (m == MODE_OFF) begin
            st      <= ST_IDLE;
            os_used <= 1'b0;
            to_cnt  <= '0;
        end else begin
            if (idle_done && (m == MODE_PERIODIC) && rate_on)
                pcnt <= p_wrap ? 8'd0 : pcnt + 8'd1;
            if (arm) begin
                st       <= ST_ARMED;
                inj_seed <= rnd;
                inj_type <= pick_type(rnd[15:0], mask);
                if (m == MODE_ONESHOT)
                    os_used <= 1'b1;
            end
            if (inj_active) begin
                st      <= ST_CHECK;
                to_cnt  <= '0;
                cnt_inj <= sat_inc(cnt_inj);
            end
            if (st == ST_CHECK) begin
                if (det) begin
                    st      <= ST_IDLE;
                    cnt_det <= sat_inc(cnt_det);
                end else if (inj_failed) begin
                    st       <= ST_IDLE;
                    cnt_miss <= sat_inc(cnt_miss);
                end else begin
                    to_cnt <= to_cnt + 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/cap_err_sched.sv
// CHERI error-injection scheduler: shared LFSR plus N_CH independent channels.
// Ports: clk/rst, per-channel cfg_*, req_*, chk_* inputs; inj_* and cnt_* per-channel outputs.
module cap_err_sched
    import cap_err_pkg::*;
#(
    parameter int          N_CH      = 2,
    parameter int          N_TYPES   = 5,
    parameter int          CNT_W     = 16,
    parameter int          TO_CYC    = 64,
    parameter logic [31:0] LFSR_SEED = 32'h1,
    localparam int         TYPE_W    = $clog2(N_TYPES)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [2*N_CH-1:0]       cfg_mode,
    input  logic [3*N_CH-1:0]       cfg_rate,
    input  logic [N_TYPES*N_CH-1:0] cfg_type_mask,
    input  logic [N_CH-1:0]         req_valid,
    input  logic [N_CH-1:0]         req_excl,
    input  logic [N_CH-1:0]         req_done,
    input  logic [N_CH-1:0]         chk_valid,
    input  logic [N_CH-1:0]         chk_err,
    output logic [N_CH-1:0]         inj_active,
    output logic [TYPE_W*N_CH-1:0]  inj_type,
    output logic [32*N_CH-1:0]      inj_seed,
    output logic [N_CH-1:0]         inj_failed,
    output logic [CNT_W*N_CH-1:0]   cnt_inj,
    output logic [CNT_W*N_CH-1:0]   cnt_det,
    output logic [CNT_W*N_CH-1:0]   cnt_miss
);

    if (LFSR_SEED == 32'h0) begin : g_bad_seed
        $error("cap_err_sched: LFSR_SEED must be non-zero");
    end

    logic [31:0] lfsr;

    always_ff @(posedge clk) begin
        if (rst)
            lfsr <= LFSR_SEED;
        else
            lfsr <= lfsr_step(lfsr);
    end

    for (genvar c = 0; c < N_CH; c++) begin : g_ch
        localparam int SH = (8 * c) % 32;

        logic [31:0] rnd;

        // Each channel sees the LFSR rotated left by 8*c.
        if (SH == 0) begin : g_rot0
            assign rnd = lfsr;
        end else begin : g_rot
            assign rnd = {lfsr[31-SH:0], lfsr[31:32-SH]};
        end

        cap_err_chan #(
            .N_TYPES (N_TYPES),
            .TYPE_W  (TYPE_W),
            .CNT_W   (CNT_W),
            .TO_CYC  (TO_CYC)
        ) u_chan (
            .clk        (clk),
            .rst        (rst),
            .mode       (cfg_mode[2*c +: 2]),
            .rate       (cfg_rate[3*c +: 3]),
            .mask       (cfg_type_mask[N_TYPES*c +: N_TYPES]),
            .rnd        (rnd),
            .req_valid  (req_valid[c]),
            .req_excl   (req_excl[c]),
            .req_done   (req_done[c]),
            .chk_valid  (chk_valid[c]),
            .chk_err    (chk_err[c]),
            .inj_active (inj_active[c]),
            .inj_type   (inj_type[TYPE_W*c +: TYPE_W]),
            .inj_seed   (inj_seed[32*c +: 32]),
            .inj_failed (inj_failed[c]),
            .cnt_inj    (cnt_inj[CNT_W*c +: CNT_W]),
            .cnt_det    (cnt_det[CNT_W*c +: CNT_W]),
            .cnt_miss   (cnt_miss[CNT_W*c +: CNT_W])
        );
    end

endmodule

// File: doc/cap_err_sched.md
CAP_ERR_SCHED -- requirements
Module: cap_err_sched

Interface
REQ-001 Parameter N_CH, default 2: number of independent injection channels (LSU, fetch, ...).
REQ-002 Parameter N_TYPES, default 5: error types per channel; TYPE_W = $clog2(N_TYPES).
REQ-003 Parameter CNT_W, default 16: statistics counter width.
REQ-004 Parameter TO_CYC, default 64: CHECK-state timeout in cycles.
REQ-005 Parameter LFSR_SEED, default 32'h1; zero SHALL be rejected by elaboration assertion.
REQ-006 One clock, synchronous active-high reset: clk in 1 clock; rst in 1 reset.
REQ-007 cfg_mode in 2*N_CH: per channel 0=OFF, 1=RANDOM, 2=PERIODIC, 3=ONESHOT.
REQ-008 cfg_rate in 3*N_CH: per-channel rate; 0 = never inject.
REQ-009 cfg_type_mask in N_TYPES*N_CH: per-channel enabled error types.
REQ-010 req_valid in N_CH: a checked access is presented this cycle.
REQ-011 req_excl in N_CH: the current access is in an excluded window (ISR); do not inject.
REQ-012 req_done in N_CH: the instruction owning the access retired.
REQ-013 chk_valid in N_CH: the checker result is valid; chk_err in N_CH: the checker flagged a CHERI fault.
REQ-014 inj_active out N_CH: corrupt the current access.
REQ-015 inj_type out TYPE_W*N_CH: selected error type.
REQ-016 inj_seed out 32*N_CH: latched seed for sub-choices.
REQ-017 inj_failed out N_CH: one-cycle pulse, injection not detected.
REQ-018 cnt_inj, cnt_det, cnt_miss out CNT_W*N_CH: per-channel statistics.

Function
REQ-019 A single 32-bit Galois LFSR, taps 32'h8020_0003, SHALL advance every non-reset cycle; channel c SHALL use it rotated left by 8*c.
REQ-020 Each channel SHALL run the FSM IDLE -> ARMED -> INJECT -> CHECK -> IDLE.
REQ-021 IDLE, req_done, mode RANDOM, rate!=0: arm when the low (8-rate) LFSR bits are all zero, i.e. probability 2^-(8-rate).
REQ-022 IDLE, req_done, mode PERIODIC, rate!=0: an 8-bit done counter SHALL arm the channel when it reaches 2^(8-rate)-1, then clear.
REQ-023 IDLE, req_done, mode ONESHOT: arm once; no further arming until the mode passes through OFF.
REQ-024 On arming, inj_seed and inj_type SHALL be latched; type = seed[15:0] mod N_TYPES, advanced upward with wrap to the next enabled mask bit.
REQ-025 An all-zero type mask SHALL suppress arming.
REQ-026 ARMED: inj_active SHALL be combinational req_valid & ~req_excl (zero latency); that cycle is INJECT; cnt_inj++; the channel enters CHECK next cycle.
REQ-027 ARMED with req_excl: stay ARMED, inj_active=0.
REQ-028 CHECK, chk_valid & chk_err: cnt_det++, go to IDLE.
REQ-029 CHECK, chk_valid & ~chk_err, or TO_CYC cycles elapsed: inj_failed pulse, cnt_miss++, go to IDLE.
REQ-030 req_done in ARMED/CHECK SHALL be ignored; chk_valid outside CHECK SHALL be ignored.
REQ-031 Mode written to OFF in any state: next cycle IDLE, no counter update, inj_active=0.
REQ-032 Counters SHALL saturate at all-ones.
REQ-033 Channels SHALL be independent; simultaneous events on different channels SHALL both be processed.

Reset
REQ-034 rst SHALL set LFSR=LFSR_SEED, all FSMs IDLE, and all counters, inj_seed, inj_type, ONESHOT flags, timeout and period counters to 0.
REQ-035 During rst, inj_active and inj_failed SHALL be 0; rst mid-CHECK SHALL abandon without a failed pulse.

Structure
REQ-036 Shared package cap_err_pkg SHALL hold the mode enum, channel state enum, and LFSR tap constant.
REQ-037 Sub-module cap_err_chan SHALL implement one channel FSM plus counters, generated N_CH times; the LFSR lives in the top.

Verification
REQ-038 RANDOM, rate=7, mask=5'b11111, 1000 req_done: roughly 500 arms; cnt_inj=cnt_det+cnt_miss at the end.
REQ-039 PERIODIC, rate=6, req_done every cycle: arm exactly every 4th done.
REQ-040 ONESHOT, mask=5'b00100: exactly one injection, type=2, even after 100 done events; OFF then ONESHOT re-arms once.
REQ-041 Armed, req_valid with req_excl=1 for 3 cycles, then without: inj_active only on the 4th access.
REQ-042 CHECK with no chk_valid for 64 cycles: inj_failed pulses once, cnt_miss=1; chk_err=1 instead gives cnt_det=1.
REQ-043 cnt_inj preloaded to all-ones via CNT_W=2 and 5 injections: the count stays at 3; rst mid-CHECK gives no pulse and all outputs 0.
